// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline latches: default bundle widths,
// the bubble control word and the EX/M/WB control field layout.
package pipe_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int CTRL_W_DEF = 8;

  // Control bundle layout, most significant field first: {ex, m, wb}
  localparam int CTRL_EX_W = 4;
  localparam int CTRL_M_W  = 2;
  localparam int CTRL_WB_W = 2;

  localparam logic [CTRL_W_DEF-1:0] CTRL_NOP = '0;

  function automatic logic [CTRL_W_DEF-1:0] pack_ctrl(
    input logic [CTRL_EX_W-1:0] ex,
    input logic [CTRL_M_W-1:0]  m,
    input logic [CTRL_WB_W-1:0] wb
  );
    return {ex, m, wb};
  endfunction

endpackage

// File: rtl/pipe_latch_elastic_if.sv
// Handshake bundle between two pipeline stages through one elastic latch.
interface pipe_latch_elastic_if #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8
);
  // A transfer happens on an edge where valid and ready are both high; valid
  // must not wait on ready, and the producer holds its bundle until it is taken.
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;

  modport slave (
    input  in_valid, in_data, in_ctrl, out_ready,
    output in_ready, out_valid, out_data, out_ctrl
  );

  modport master (
    output in_valid, in_data, in_ctrl, out_ready,
    input  in_ready, out_valid, out_data, out_ctrl
  );
endinterface

// File: rtl/pipe_slot_array.sv
// DEPTH x W register array: one synchronous write port, one asynchronous read port.
module pipe_slot_array #(
  parameter int DEPTH = 2,
  parameter int W     = 40,
  parameter int PTR_W = 1
) (
  input  logic             clock,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  logic [W-1:0]     wdata,
  input  logic [PTR_W-1:0] raddr,
  output logic [W-1:0]     rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pipe_latch_elastic.sv
// Elastic pipeline latch: DEPTH-entry FIFO with valid/ready, flush and bubble
// insertion. Define PIPE_STALL_CNT_EN to add the saturating stall_cnt output.
module pipe_latch_elastic
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       flush,
  pipe_latch_elastic_if.slave        bus,
`ifdef PIPE_STALL_CNT_EN
  output logic [CNT_W-1:0]           stall_cnt,
`endif
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SLOT_W = CTRL_W + DATA_W;

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              push;
  logic              pop;
  logic [SLOT_W-1:0] head;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // in_ready depends only on registered occupancy, never on out_ready
  assign bus.in_ready  = (occupancy != OCC_W'(DEPTH));
  assign bus.out_valid = (occupancy != '0);

  assign push = bus.in_valid & bus.in_ready & ~flush;
  assign pop  = bus.out_valid & bus.out_ready & ~flush;

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (push) wr_ptr <= ptr_next(wr_ptr);
      if (pop)  rd_ptr <= ptr_next(rd_ptr);
      case ({push, pop})
        2'b10:   occupancy <= occupancy + OCC_W'(1);
        2'b01:   occupancy <= occupancy - OCC_W'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

  pipe_slot_array #(
    .DEPTH (DEPTH),
    .W     (SLOT_W),
    .PTR_W (PTR_W)
  ) u_slots (
    .clock (clock),
    .we    (push & ~reset),
    .waddr (wr_ptr),
    .wdata ({bus.in_ctrl, bus.in_data}),
    .raddr (rd_ptr),
    .rdata (head)
  );

  // Stale slot contents are masked so an empty latch always emits a bubble
  always_comb begin
    bus.out_data = '0;
    bus.out_ctrl = CTRL_W'(CTRL_NOP);
    if (bus.out_valid) begin
      bus.out_data = head[DATA_W-1:0];
      bus.out_ctrl = head[SLOT_W-1:DATA_W];
    end
  end

`ifdef PIPE_STALL_CNT_EN
  // Counts head-blocked cycles; survives flush so stall statistics persist
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (bus.out_valid && !bus.out_ready && !(&stall_cnt)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_latch_elastic.sv
// Bench for pipe_latch_elastic: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a queue model.
module tb_pipe_latch_elastic;

  localparam int DATA_W = 32;
  localparam int CTRL_W = 8;
  localparam int DEPTH  = 2;
  localparam int CNT_W  = 16;
  localparam int OCC_W  = $clog2(DEPTH + 1);
  localparam int W      = CTRL_W + DATA_W;

  // clock / reset
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;
  always #5 clock = ~clock;

  pipe_latch_elastic_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) bus ();
  logic [OCC_W-1:0] occupancy;
`ifdef PIPE_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt;
`endif

  pipe_latch_elastic #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .bus       (bus.slave),
`ifdef PIPE_STALL_CNT_EN
    .stall_cnt (stall_cnt),
`endif
    .occupancy (occupancy)
  );

  // scoreboard
  logic [W-1:0] exp_q[$];
  int           vectors    = 0;
  int           miscompares = 0;
  bit           chk_en     = 1'b0;
  longint       exp_stall  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Compare outputs against the queue model, then advance the model by one edge
  always @(negedge clock) begin
    logic [W-1:0] head;
    bit do_push, do_pop;
    head = (exp_q.size() > 0) ? exp_q[0] : '0;
    if (chk_en) begin
      check("occupancy", 64'(occupancy), 64'(exp_q.size()));
      check("out_valid", 64'(bus.out_valid), 64'(exp_q.size() > 0));
      check("in_ready",  64'(bus.in_ready),  64'(exp_q.size() < DEPTH));
      check("out_data",  64'(bus.out_data),  64'(head[DATA_W-1:0]));
      check("out_ctrl",  64'(bus.out_ctrl),  64'(head[W-1:DATA_W]));
`ifdef PIPE_STALL_CNT_EN
      check("stall_cnt", 64'(stall_cnt), 64'(exp_stall));
`endif
    end
    if (reset) begin
      exp_stall = 0;
    end else if (exp_q.size() > 0 && !bus.out_ready && exp_stall < (64'd1 << CNT_W) - 1) begin
      exp_stall++;
    end
    do_push = bus.in_valid && (exp_q.size() < DEPTH);
    do_pop  = (exp_q.size() > 0) && bus.out_ready;
    if (reset || flush) begin
      exp_q.delete();
    end else begin
      if (do_pop)  void'(exp_q.pop_front());
      if (do_push) exp_q.push_back({bus.in_ctrl, bus.in_data});
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input bit v, input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c,
                       input bit ordy);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.in_ctrl   = c;
    bus.out_ready = ordy;
  endtask

  initial begin
    drive(1'b0, '0, '0, 1'b0);
    reset = 1'b1;
    tick();
    chk_en = 1'b1;
    tick();

    // reset values
    check("rst_occ",      64'(occupancy),     64'd0);
    check("rst_in_ready", 64'(bus.in_ready),  64'd1);
    check("rst_valid",    64'(bus.out_valid), 64'd0);
    check("rst_data",     64'(bus.out_data),  64'd0);
    check("rst_ctrl",     64'(bus.out_ctrl),  64'd0);
    reset = 1'b0;

    // single transfer, one-cycle latency
    drive(1'b1, 32'h0000_00AA, 8'h5A, 1'b1);
    tick();
    drive(1'b0, '0, '0, 1'b1);
    check("t1_valid", 64'(bus.out_valid), 64'd1);
    check("t1_data",  64'(bus.out_data),  64'hAA);
    check("t1_ctrl",  64'(bus.out_ctrl),  64'h5A);
    check("t1_occ",   64'(occupancy),     64'd1);
    tick();
    check("t1_occ_after", 64'(occupancy), 64'd0);

    // fill, back-pressure, drain in order
    drive(1'b1, 32'h1, 8'h01, 1'b0); tick();
    drive(1'b1, 32'h2, 8'h02, 1'b0); tick();
    check("t2_full_occ",   64'(occupancy),    64'd2);
    check("t2_full_ready", 64'(bus.in_ready), 64'd0);
    drive(1'b1, 32'h3, 8'h03, 1'b0); tick();
    check("t2_held_occ",  64'(occupancy),    64'd2);
    check("t2_held_head", 64'(bus.out_data), 64'h1);
    drive(1'b1, 32'h3, 8'h03, 1'b1); tick();
    check("t2_head2", 64'(bus.out_data), 64'h2);
    check("t2_occ1",  64'(occupancy),    64'd1);
    tick();
    drive(1'b0, '0, '0, 1'b1);
    check("t2_head3", 64'(bus.out_data), 64'h3);
    tick();
    check("t2_drained", 64'(occupancy), 64'd0);

    // streaming, one transfer per cycle across pointer wrap
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 32'(100 + i), 8'(i), 1'b1);
      tick();
      check("t3_occ",  64'(occupancy),    64'd1);
      check("t3_data", 64'(bus.out_data), 64'(100 + i));
    end
    drive(1'b0, '0, '0, 1'b1);
    tick();

    // flush while full with an incoming transfer
    drive(1'b1, 32'hA, 8'h0A, 1'b0); tick();
    drive(1'b1, 32'hB, 8'h0B, 1'b0); tick();
    drive(1'b1, 32'h9, 8'h09, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, '0, '0, 1'b1);
    check("t4_occ",   64'(occupancy),     64'd0);
    check("t4_valid", 64'(bus.out_valid), 64'd0);
    check("t4_ctrl",  64'(bus.out_ctrl),  64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t4_no_9", 64'(bus.out_valid), 64'd0);
    end

    // reset while full with an incoming transfer
    drive(1'b1, 32'hC, 8'h0C, 1'b0); tick();
    drive(1'b1, 32'hD, 8'h0D, 1'b0); tick();
    drive(1'b1, 32'hE, 8'h0E, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5_occ",   64'(occupancy),     64'd0);
    check("t5_ready", 64'(bus.in_ready),  64'd1);
    check("t5_valid", 64'(bus.out_valid), 64'd0);
    check("t5_data",  64'(bus.out_data),  64'd0);
    drive(1'b1, 32'h7, 8'h07, 1'b0); tick();
    drive(1'b0, '0, '0, 1'b0);
    check("t5_data7", 64'(bus.out_data), 64'h7);
    drive(1'b0, '0, '0, 1'b1);
    tick();

`ifdef PIPE_STALL_CNT_EN
    reset = 1'b1; tick(); reset = 1'b0;
    drive(1'b1, 32'h5, 8'h05, 1'b0); tick();
    drive(1'b0, '0, '0, 1'b0);
    repeat (5) tick();
    check("t6_stall5", 64'(stall_cnt), 64'd5);
    drive(1'b0, '0, '0, 1'b1);
    flush = 1'b1; tick(); flush = 1'b0;
    check("t6_flush_keeps", 64'(stall_cnt), 64'd5);
    reset = 1'b1; tick(); reset = 1'b0;
    check("t6_reset_clears", 64'(stall_cnt), 64'd0);
`endif

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 32'($urandom), 8'($urandom),
            1'($urandom_range(0, 2) != 0));
      flush = ($urandom_range(0, 39) == 0);
      reset = ($urandom_range(0, 199) == 0);
      tick();
    end
    flush = 1'b0;
    reset = 1'b0;
    drive(1'b0, '0, '0, 1'b1);
    repeat (3) tick();
    @(negedge clock);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
